mem_seq_engine: RTL and testbench

- Parametrised successor to the game's random-number and check logic: generates an N-digit random sequence, holds it for display, then checks player digits one at a time.
- Each player digit arrives as a single-cycle valid pulse.
- A 16-bit Galois LFSR replaces simulation-only randomness, so the block is synthesizable and reproducible from a seed.
- Sits between the game-control FSM (round start, display, score) and the keypad/switch debouncer.

---
 rtl/mem_seq_engine.sv | 165 ++++++++++++++++
 tb/tb_mem_seq_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_engine.sv
// Memory-sequence engine: builds an N-digit pseudo-random sequence from a free-running
// Galois LFSR, holds it for display, then scores player digits one strobe at a time.
module mem_seq_engine #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned DIGIT_MOD  = 9,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter bit          EARLY_FAIL = 1'b0,
  localparam int unsigned IdxW      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          seed_load,
  input  logic [15:0]                   seed_in,
  input  logic                          new_round,
  input  logic                          user_valid,
  input  logic [DIGIT_W-1:0]            user_digit,
  output logic                          busy,
  output logic                          seq_valid,
  output logic [NUM_DIGITS*DIGIT_W-1:0] seq_out,
  output logic [IdxW-1:0]               digit_idx,
  output logic                          result_valid,
  output logic                          correct,
  output logic [IdxW-1:0]               err_count
);

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StInput,
    StDone
  } state_e;

  localparam logic [15:0] LfsrMask = 16'hB400;

  state_e                                 state_q, state_d;
  logic [15:0]                            lfsr_q, lfsr_d, lfsr_step;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     seq_q, seq_d;
  logic [IdxW-1:0]                        gen_k_q, gen_k_d;
  logic [IdxW-1:0]                        idx_q, idx_d;
  logic [IdxW-1:0]                        err_q, err_d;
  logic                                   seq_valid_q, seq_valid_d;
  logic                                   result_valid_q, result_valid_d;
  logic                                   correct_q, correct_d;

  logic [DIGIT_W-1:0]                     gen_digit;
  logic [DIGIT_W-1:0]                     exp_digit;
  logic                                   mismatch;
  logic [IdxW-1:0]                        idx_inc;
  logic [IdxW-1:0]                        err_next;
  logic                                   gen_last;
  logic                                   input_last;

  // The LFSR runs in every state so player timing perturbs the next sequence.
  always_comb begin
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
    if (seed_load) begin
      lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
    end else begin
      lfsr_d = lfsr_step;
    end
  end

  assign gen_digit = DIGIT_W'(32'(lfsr_q[7:0]) % DIGIT_MOD);
  assign gen_last  = (gen_k_q == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        exp_digit = seq_q[i];
      end
    end
  end

  assign mismatch   = (user_digit != exp_digit);
  assign idx_inc    = idx_q + IdxW'(1);
  assign err_next   = err_q + IdxW'(mismatch);
  assign input_last = (idx_inc == IdxW'(NUM_DIGITS));

  always_comb begin
    state_d        = state_q;
    seq_d          = seq_q;
    gen_k_d        = gen_k_q;
    idx_d          = idx_q;
    err_d          = err_q;
    seq_valid_d    = seq_valid_q;
    result_valid_d = result_valid_q;
    correct_d      = correct_q;

    unique case (state_q)
      StGen: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (gen_k_q == IdxW'(i)) begin
            seq_d[i] = gen_digit;
          end
        end
        if (gen_last) begin
          state_d     = StInput;
          seq_valid_d = 1'b1;
        end else begin
          gen_k_d = gen_k_q + IdxW'(1);
        end
      end

      StIdle, StInput, StDone: begin
        if (new_round) begin
          // Also aborts a round in progress; a coincident digit is dropped.
          state_d        = StGen;
          gen_k_d        = '0;
          idx_d          = '0;
          err_d          = '0;
          seq_valid_d    = 1'b0;
          result_valid_d = 1'b0;
          correct_d      = 1'b0;
        end else if (state_q == StInput && user_valid) begin
          idx_d = idx_inc;
          err_d = err_next;
          if (input_last || (EARLY_FAIL && mismatch)) begin
            state_d        = StDone;
            result_valid_d = 1'b1;
            correct_d      = (err_next == '0);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      lfsr_q         <= SEED;
      seq_q          <= '0;
      gen_k_q        <= '0;
      idx_q          <= '0;
      err_q          <= '0;
      seq_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      correct_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      seq_q          <= seq_d;
      gen_k_q        <= gen_k_d;
      idx_q          <= idx_d;
      err_q          <= err_d;
      seq_valid_q    <= seq_valid_d;
      result_valid_q <= result_valid_d;
      correct_q      <= correct_d;
    end
  end

  assign busy         = (state_q == StGen);
  assign seq_valid    = seq_valid_q;
  assign seq_out      = seq_q;
  assign digit_idx    = idx_q;
  assign result_valid = result_valid_q;
  assign correct      = correct_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_mem_seq_engine.sv
// Bench for mem_seq_engine: two instances (EARLY_FAIL 0 and 1) share stimulus; sequences
// and round results are scored against a reference LFSR and expected-result queues.
module tb_mem_seq_engine;

  localparam int          N    = 4;
  localparam int          W    = 4;
  localparam int          MOD  = 9;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  logic        new_round = 1'b0;
  logic        user_valid = 1'b0;
  logic [3:0]  user_digit = 4'h0;

  logic        busy_a, seq_valid_a, result_valid_a, correct_a;
  logic [15:0] seq_out_a;
  logic [2:0]  digit_idx_a, err_count_a;
  logic        busy_b, seq_valid_b, result_valid_b, correct_b;
  logic [15:0] seq_out_b;
  logic [2:0]  digit_idx_b, err_count_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       correct;
    logic [2:0] err;
  } res_t;

  logic [15:0] seq_sb[$];
  res_t        res_sb[$];
  logic [15:0] model_lfsr;

  mem_seq_engine #(
    .NUM_DIGITS(N), .DIGIT_W(W), .DIGIT_MOD(MOD), .SEED(SEED), .EARLY_FAIL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .new_round(new_round), .user_valid(user_valid), .user_digit(user_digit),
    .busy(busy_a), .seq_valid(seq_valid_a), .seq_out(seq_out_a),
    .digit_idx(digit_idx_a), .result_valid(result_valid_a), .correct(correct_a),
    .err_count(err_count_a)
  );

  mem_seq_engine #(
    .NUM_DIGITS(N), .DIGIT_W(W), .DIGIT_MOD(MOD), .SEED(SEED), .EARLY_FAIL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .new_round(new_round), .user_valid(user_valid), .user_digit(user_digit),
    .busy(busy_b), .seq_valid(seq_valid_b), .seq_out(seq_out_b),
    .digit_idx(digit_idx_b), .result_valid(result_valid_b), .correct(correct_b),
    .err_count(err_count_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] seq_from(input logic [15:0] start);
    logic [15:0] s;
    logic [15:0] v;
    s = '0;
    v = start;
    for (int k = 0; k < N; k++) begin
      s[k*W +: W] = 4'(32'(v[7:0]) % MOD);
      v = lfsr_next(v);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) model_lfsr <= SEED;
    else if (seed_load) model_lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
    else model_lfsr <= lfsr_next(model_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the new_round edge the reference LFSR holds the value used for digit 0.
  task automatic start_round(input logic load, input logic [15:0] seed);
    seed_load = load;
    seed_in   = seed;
    new_round = 1'b1;
    tick();
    seed_load = 1'b0;
    new_round = 1'b0;
    seq_sb.push_back(seq_from(model_lfsr));
  endtask

  task automatic enter(input logic [3:0] d);
    user_valid = 1'b1;
    user_digit = d;
    tick();
    user_valid = 1'b0;
  endtask

  task automatic wait_seq(output bit ok);
    int n;
    n = 0;
    while (!seq_valid_a && n < 40) begin
      tick();
      n++;
    end
    ok = seq_valid_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_a, seq_valid_a, result_valid_a, correct_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {busy_a, seq_valid_a, result_valid_a, correct_a});
    end
    checks++;
    if (seq_out_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_seq_out got %h want 0000", seq_out_a);
    end
    checks++;
    if ({digit_idx_a, err_count_a} !== 6'd0) begin
      errors++;
      $display("FAIL reset_counters got idx %0d err %0d want 0 0", digit_idx_a, err_count_a);
    end
    checks++;
    if (dut_a.lfsr_q !== SEED) begin
      errors++;
      $display("FAIL reset_lfsr got %h want %h", dut_a.lfsr_q, SEED);
    end
    rst = 1'b0;
  endtask

  task automatic test_bring_up();
    logic [15:0] exp;
    start_round(1'b1, 16'h0005);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (busy_a !== 1'b1 || seq_valid_a !== 1'b0) begin
        errors++;
        $display("FAIL gen_busy cycle %0d got busy %b seq_valid %b want 1 0", i, busy_a, seq_valid_a);
      end
      tick();
    end
    checks++;
    if (busy_a !== 1'b0 || seq_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL gen_latency got busy %b seq_valid %b want 0 1", busy_a, seq_valid_a);
    end
    checks++;
    if (seq_out_a !== 16'h0125) begin
      errors++;
      $display("FAIL bring_up_seq got %h want 0125", seq_out_a);
    end
    exp = seq_sb.pop_front();
    checks++;
    if (seq_out_b !== exp) begin
      errors++;
      $display("FAIL bring_up_seq_b got %h want %h", seq_out_b, exp);
    end
  endtask

  task automatic test_all_correct();
    logic [3:0] digs [4];
    res_t r;
    digs = '{4'd5, 4'd2, 4'd1, 4'd0};
    res_sb.push_back('{correct: 1'b1, err: 3'd0});
    for (int i = 0; i < N; i++) begin
      enter(digs[i]);
      checks++;
      if (digit_idx_a !== 3'(i + 1) || result_valid_a !== (i == N - 1)) begin
        errors++;
        $display("FAIL all_correct_step %0d got idx %0d rv %b want %0d %b",
                 i, digit_idx_a, result_valid_a, i + 1, (i == N - 1));
      end
      tick();
    end
    r = res_sb.pop_front();
    checks++;
    if (correct_a !== r.correct || err_count_a !== r.err) begin
      errors++;
      $display("FAIL all_correct_result got c %b err %0d want %b %0d",
               correct_a, err_count_a, r.correct, r.err);
    end
    checks++;
    if (result_valid_b !== 1'b1 || correct_b !== 1'b1) begin
      errors++;
      $display("FAIL all_correct_b got rv %b c %b want 1 1", result_valid_b, correct_b);
    end
  endtask

  task automatic test_two_wrong_early_fail();
    logic [3:0]  digs [4];
    logic [15:0] exp;
    res_t        r;
    bit          ok;
    digs = '{4'd5, 4'd3, 4'd1, 4'd7};
    start_round(1'b1, 16'h0005);
    wait_seq(ok);
    exp = seq_sb.pop_front();
    checks++;
    if (!ok || seq_out_a !== exp) begin
      errors++;
      $display("FAIL wrong_seq got %h valid %b want %h", seq_out_a, seq_valid_a, exp);
    end
    res_sb.push_back('{correct: 1'b0, err: 3'd2});
    for (int i = 0; i < N; i++) begin
      enter(digs[i]);
      if (i == 1) begin
        checks++;
        if ({result_valid_b, correct_b, err_count_b, digit_idx_b} !== {1'b1, 1'b0, 3'd1, 3'd2}) begin
          errors++;
          $display("FAIL early_fail got rv %b c %b err %0d idx %0d want 1 0 1 2",
                   result_valid_b, correct_b, err_count_b, digit_idx_b);
        end
      end
      if (i >= 2) begin
        checks++;
        if (digit_idx_b !== 3'd2 || err_count_b !== 3'd1) begin
          errors++;
          $display("FAIL early_fail_hold got idx %0d err %0d want 2 1", digit_idx_b, err_count_b);
        end
      end
      if (i < N - 1) begin
        checks++;
        if (result_valid_a !== 1'b0) begin
          errors++;
          $display("FAIL two_wrong_early_rv step %0d got %b want 0", i, result_valid_a);
        end
      end
      tick();
    end
    r = res_sb.pop_front();
    checks++;
    if (result_valid_a !== 1'b1 || correct_a !== r.correct || err_count_a !== r.err) begin
      errors++;
      $display("FAIL two_wrong_result got rv %b c %b err %0d want 1 %b %0d",
               result_valid_a, correct_a, err_count_a, r.correct, r.err);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    res_t        r;
    bit          ok;
    start_round(1'b1, 16'h0000);
    wait_seq(ok);
    exp = seq_sb.pop_front();
    checks++;
    if (!ok || seq_out_a !== exp || seq_out_a[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL zero_seed_seq got %h want %h (digit0 0)", seq_out_a, exp);
    end
    enter(exp[3:0]);
    enter(exp[7:4]);
    // Abort with a coincident digit strobe.
    new_round  = 1'b1;
    user_valid = 1'b1;
    user_digit = exp[11:8];
    tick();
    new_round  = 1'b0;
    user_valid = 1'b0;
    seq_sb.push_back(seq_from(model_lfsr));
    checks++;
    if ({busy_a, seq_valid_a, result_valid_a, digit_idx_a, err_count_a} !== {3'b100, 6'd0}) begin
      errors++;
      $display("FAIL abort_state got busy %b sv %b rv %b idx %0d err %0d want 1 0 0 0 0",
               busy_a, seq_valid_a, result_valid_a, digit_idx_a, err_count_a);
    end
    enter(4'd1);
    enter(4'd2);
    wait_seq(ok);
    exp = seq_sb.pop_front();
    checks++;
    if (!ok || seq_out_a !== exp || digit_idx_a !== 3'd0 || err_count_a !== 3'd0) begin
      errors++;
      $display("FAIL abort_regen got seq %h idx %0d err %0d want %h 0 0",
               seq_out_a, digit_idx_a, err_count_a, exp);
    end
    // Out-of-range digit in the last slot always mismatches.
    res_sb.push_back('{correct: 1'b0, err: 3'd1});
    enter(exp[3:0]);
    enter(exp[7:4]);
    enter(exp[11:8]);
    enter(4'hF);
    r = res_sb.pop_front();
    checks++;
    if (result_valid_a !== 1'b1 || correct_a !== r.correct || err_count_a !== r.err) begin
      errors++;
      $display("FAIL out_of_range_digit got rv %b c %b err %0d want 1 %b %0d",
               result_valid_a, correct_a, err_count_a, r.correct, r.err);
    end
  endtask

  task automatic test_reset_mid_gen();
    logic [15:0] exp;
    bit          ok;
    start_round(1'b0, 16'h0000);
    void'(seq_sb.pop_back());
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy_a, seq_valid_a, result_valid_a, correct_a, digit_idx_a, err_count_a} !== 10'd0
        || seq_out_a !== 16'h0000 || dut_a.lfsr_q !== SEED) begin
      errors++;
      $display("FAIL mid_gen_reset got busy %b sv %b seq %h lfsr %h want 0 0 0000 %h",
               busy_a, seq_valid_a, seq_out_a, dut_a.lfsr_q, SEED);
    end
    tick();
    tick();
    tick();
    start_round(1'b0, 16'h0000);
    wait_seq(ok);
    exp = seq_sb.pop_front();
    checks++;
    if (!ok || seq_out_a !== exp || seq_out_b !== exp) begin
      errors++;
      $display("FAIL free_run_seq got %h / %h want %h", seq_out_a, seq_out_b, exp);
    end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_all_correct();
    test_two_wrong_early_fail();
    test_abort();
    test_reset_mid_gen();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
